pipe_mux_n: RTL and testbench
=============================

PIPE_MUX_N -- requirements
Module: pipe_mux_n

Interface
- REQ-001 Parameter WIDTH, 32, data width per input channel in bits.
- REQ-002 Parameter N, 4, number of input channels (2..16).
- REQ-003 Parameter CNTW, 16, width of the transfer counter.
- REQ-004 Derived localparam SELW = max(1, clog2(N)), the select width.
- REQ-005 clk  in  1  single clock; all state updates on its rising edge.
- REQ-006 rst  in  1  synchronous reset, active-high, sampled on rising clk.
- REQ-007 in_data  in  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- REQ-008 sel  in  SELW  channel index; sampled with the input beat.
- REQ-009 in_valid  in  1  upstream beat present.
- REQ-010 in_ready  out  1  stage can accept a beat this cycle.
- REQ-011 out_data  out  WIDTH  registered selected data.
- REQ-012 out_valid  out  1  out_data holds an unconsumed beat.
- REQ-013 out_ready  in  1  downstream accepts out_data.
- REQ-014 flush  in  1  discard the held beat (pipeline squash).
- REQ-015 err_sel  out  1  sticky flag: a beat was accepted with sel >= N.
- REQ-016 xfer_cnt  out  CNTW  count of completed output transfers.

Function
- REQ-017 Input accept occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
- REQ-018 in_ready SHALL equal !out_valid || out_ready (combinational; full throughput, one beat per cycle).
- REQ-019 On accept, out_data SHALL load channel sel of in_data and out_valid SHALL be 1 on the next cycle (latency one cycle).
- REQ-020 Out-of-range sel (sel >= N) on accept SHALL load out_data = 0 and set err_sel; the beat is still delivered.
- REQ-021 While out_valid && !out_ready, out_data and out_valid SHALL hold stable; sel and in_data changes are ignored.
- REQ-022 Transfer without a simultaneous accept SHALL clear out_valid next cycle; with a simultaneous accept, out_valid stays 1 and the new beat loads.
- REQ-023 flush SHALL clear out_valid next cycle and take priority over accept in the same cycle; the flushed beat does not increment xfer_cnt, and in_ready is forced 0 while flush is high.
- REQ-024 xfer_cnt SHALL increment by 1 per output transfer and saturate at 2^CNTW-1 (no wrap).
- REQ-025 err_sel SHALL remain set until rst; flush does not clear it.
- REQ-026 out_data SHALL retain its last value after out_valid drops (no zeroing).

Reset
- REQ-027 With rst high at a rising edge: out_valid=0, out_data=0, err_sel=0, xfer_cnt=0 next cycle.
- REQ-028 rst SHALL override flush and accept; a beat in flight mid-reset is discarded without counting.
- REQ-029 in_ready SHALL be 0 while rst is high.

Configuration
- REQ-030 Macro PIPE_MUX_N_TRACE_EN: when defined, each accepted beat SHALL print one simulation line with sel, the selected value and the cycle time; each err_sel set prints a warning line.
- REQ-031 Without PIPE_MUX_N_TRACE_EN no display statements SHALL exist; synthesised logic SHALL be identical in both cases.

Structure
- REQ-032 Package pipe_mux_pkg SHALL hold the default WIDTH/N/CNTW constants and the select-width helper function.
- REQ-033 A combinational sub-module pipe_mux_sel (N-way WIDTH-bit selector with out-of-range zeroing and range flag) SHALL be instantiated; the handshake register, counter and flag stay in pipe_mux_n.

Verification
- REQ-034 Reset: rst high 2 cycles with in_valid=1 -> out_valid=0, xfer_cnt=0, err_sel=0, in_ready=0 throughout.
- REQ-035 Streaming: N=4, out_ready=1, beats sel=0,1,2,3 with channel k = 32'hA0+k -> out_data A0,A1,A2,A3 on consecutive cycles, xfer_cnt=4.
- REQ-036 Backpressure: beat sel=2 (value 32'h1234), out_ready=0 for 3 cycles while sel/in_data change -> out_data stays 32'h1234, in_ready=0; release -> one transfer, xfer_cnt +1.
- REQ-037 Range error: N=3, sel=3 accepted -> out_data=0, out_valid=1, err_sel=1 and stays 1 after flush.
- REQ-038 Flush priority: flush and accept same cycle with held beat -> out_valid=0 next cycle, xfer_cnt unchanged.
- REQ-039 Saturation: CNTW=4, 20 transfers -> xfer_cnt=15.

Source files
------------

// File: rtl/pipe_mux_pkg.sv
// Shared defaults and select-width helper for the pipelined N-way mux.
package pipe_mux_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_N     = 4;
  localparam int DEF_CNTW  = 16;

  // At least one select bit even for degenerate channel counts.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_mux_sel.sv
// Combinational N-way selector; out-of-range selects yield zero and raise sel_oob.
module pipe_mux_sel
  import pipe_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  parameter int SELW  = sel_width(DEF_N)
) (
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   sel_data,
  output logic               sel_oob
);

  always_comb begin
    sel_data = '0;
    sel_oob  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel == SELW'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_oob  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_mux_n.sv
// One-stage registered N-way mux with valid/ready, flush, sticky range error and
// saturating transfer counter. Define PIPE_MUX_N_TRACE_EN for simulation trace lines.
module pipe_mux_n
  import pipe_mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int N      = DEF_N,
  parameter int CNTW   = DEF_CNTW,
  localparam int SELW  = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               flush,
  output logic               err_sel,
  output logic [CNTW-1:0]    xfer_cnt
);

  // Handshake: a beat moves only on a cycle where valid && ready are both high;
  // valid never depends on ready, and a presented output beat holds until taken.
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             err_sel_q, err_sel_d;
  logic [CNTW-1:0]  xfer_cnt_q, xfer_cnt_d;

  logic [WIDTH-1:0] sel_data;
  logic             sel_oob;
  logic             accept;
  logic             xfer;

  pipe_mux_sel #(
    .WIDTH (WIDTH),
    .N     (N),
    .SELW  (SELW)
  ) u_sel (
    .in_data  (in_data),
    .sel      (sel),
    .sel_data (sel_data),
    .sel_oob  (sel_oob)
  );

  assign in_ready = !rst && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  // A flushed beat is squashed, so it never counts as a transfer.
  assign xfer     = out_valid_q && out_ready && !flush;

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_sel_d   = err_sel_q;
    xfer_cnt_d  = xfer_cnt_q;

    if (xfer && (xfer_cnt_q != '1)) xfer_cnt_d = xfer_cnt_q + CNTW'(1);
    if (accept && sel_oob)           err_sel_d  = 1'b1;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_data_d  = sel_data;
      out_valid_d = 1'b1;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_sel_q   <= 1'b0;
      xfer_cnt_q  <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_sel_q   <= err_sel_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign err_sel   = err_sel_q;
  assign xfer_cnt  = xfer_cnt_q;

`ifdef PIPE_MUX_N_TRACE_EN
  always @(posedge clk) begin
    if (accept) begin
      $display("pipe_mux_n: accept sel=%0d data=%h t=%0t", sel, sel_data, $time);
      if (sel_oob && !err_sel_q)
        $display("pipe_mux_n: warning: out-of-range sel=%0d, err_sel set t=%0t", sel, $time);
    end
  end
`else
  // Trace disabled: no simulation-only logic.
`endif

endmodule

// File: tb/tb_pipe_mux_n.sv
// Bench for pipe_mux_n: two instances (N=4/CNTW=16 and N=3/CNTW=4) share one stimulus stream.
module tb_pipe_mux_n;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, in_valid, out_ready, flush;
  logic [1:0]     sel;
  logic [4*W-1:0] in_data;

  logic           in_ready_a, out_valid_a, err_a;
  logic [W-1:0]   out_data_a;
  logic [15:0]    cnt_a;
  logic           in_ready_b, out_valid_b, err_b;
  logic [W-1:0]   out_data_b;
  logic [3:0]     cnt_b;

  pipe_mux_n #(.WIDTH(W), .N(4), .CNTW(16)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready_a), .out_data(out_data_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .flush(flush), .err_sel(err_a), .xfer_cnt(cnt_a)
  );

  pipe_mux_n #(.WIDTH(W), .N(3), .CNTW(4)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data[3*W-1:0]), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready_b), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .flush(flush), .err_sel(err_b), .xfer_cnt(cnt_b)
  );

  // Reference model: the beat waiting downstream lives in a queue; the last
  // loaded value, transfer total and error flag are plain variables.
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  logic [W-1:0] last_a = '0, last_b = '0;
  int           n_xfer   = 0;
  logic         err_b_m  = 1'b0;
  bit           mon_en   = 1'b0;
  int           vecs     = 0;
  int           miss     = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare registered outputs and in_ready, then retire this cycle's events.
  always @(negedge clk) begin
    if (mon_en) begin
      logic         exp_ready;
      logic [W-1:0] pa, pb;
      exp_ready = !rst && !flush && (exp_a.size() == 0 || out_ready);
      chk("in_ready_a", W'(in_ready_a), W'(exp_ready));
      chk("in_ready_b", W'(in_ready_b), W'(exp_ready));
      chk("out_valid_a", W'(out_valid_a), W'(exp_a.size() != 0));
      chk("out_valid_b", W'(out_valid_b), W'(exp_b.size() != 0));
      chk("out_data_a", out_data_a, last_a);
      chk("out_data_b", out_data_b, last_b);
      chk("xfer_cnt_a", W'(cnt_a), W'(n_xfer & 16'hFFFF));
      chk("xfer_cnt_b", W'(cnt_b), W'((n_xfer > 15) ? 15 : n_xfer));
      chk("err_sel_a", W'(err_a), '0);
      chk("err_sel_b", W'(err_b), W'(err_b_m));

      if (rst) begin
        exp_a.delete();
        exp_b.delete();
        last_a  = '0;
        last_b  = '0;
        n_xfer  = 0;
        err_b_m = 1'b0;
      end else if (flush) begin
        if (exp_a.size() != 0) begin
          pa = exp_a.pop_front();
          pb = exp_b.pop_front();
        end
      end else if (exp_a.size() != 0 && out_ready) begin
        pa = exp_a.pop_front();
        pb = exp_b.pop_front();
        chk("scoreboard_a", out_data_a, pa);
        chk("scoreboard_b", out_data_b, pb);
        n_xfer++;
      end
    end
  end

  function automatic logic [4*W-1:0] mk(input logic [W-1:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [4*W-1:0] rnd_data();
    return mk($urandom, $urandom, $urandom, $urandom);
  endfunction

  // Drive one cycle; after the monitor has retired events, push the expected beat if accepted.
  task automatic cycle(input logic r, input logic v, input logic [1:0] s,
                       input logic ordy, input logic fl, input logic [4*W-1:0] d);
    logic [W-1:0] va;
    @(posedge clk);
    #1;
    rst = r; in_valid = v; sel = s; out_ready = ordy; flush = fl; in_data = d;
    @(negedge clk);
    #1;
    if (!r && !fl && v && (exp_a.size() == 0 || ordy)) begin
      va = d[s*W +: W];
      exp_a.push_back(va);
      last_a = va;
      if (s == 2'd3) begin
        exp_b.push_back('0);
        last_b  = '0;
        err_b_m = 1'b1;
      end else begin
        exp_b.push_back(va);
        last_b = va;
      end
    end
  endtask

  initial begin
    logic [4*W-1:0] d;
    rst = 1'b1; in_valid = 1'b1; sel = '0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset held with a beat offered
    cycle(1, 1, 2'd1, 1, 0, rnd_data());
    cycle(1, 1, 2'd2, 1, 0, rnd_data());

    // Streaming A0..A3
    d = mk(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    for (int k = 0; k < 4; k++) cycle(0, 1, 2'(k), 1, 0, d);
    cycle(0, 0, 2'd0, 1, 0, d);

    // Backpressure: held beat ignores changing sel/in_data
    cycle(0, 1, 2'd2, 0, 0, mk($urandom, $urandom, 32'h1234, $urandom));
    for (int k = 0; k < 3; k++) cycle(0, 1, 2'($urandom_range(0, 3)), 0, 0, rnd_data());
    cycle(0, 0, 2'd0, 1, 0, rnd_data());
    cycle(0, 0, 2'd0, 1, 0, rnd_data());

    // Range error then flush; flag stays set
    cycle(0, 1, 2'd3, 0, 0, rnd_data());
    cycle(0, 0, 2'd0, 0, 1, rnd_data());
    cycle(0, 0, 2'd0, 1, 0, rnd_data());

    // Flush beats a simultaneous accept and transfer
    cycle(0, 1, 2'd1, 0, 0, rnd_data());
    cycle(0, 1, 2'd2, 1, 1, rnd_data());
    cycle(0, 0, 2'd0, 1, 0, rnd_data());

    // Saturation of the narrow counter
    for (int k = 0; k < 20; k++) cycle(0, 1, 2'($urandom_range(0, 2)), 1, 0, rnd_data());
    cycle(0, 0, 2'd0, 1, 0, rnd_data());

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 7) == 0), rnd_data());
    end

    // Bounded drain
    for (int k = 0; k < 10 && exp_a.size() != 0; k++) cycle(0, 0, 2'd0, 1, 0, rnd_data());
    vecs++;
    if (exp_a.size() != 0) begin
      miss++;
      $display("FAIL drain: %0d beats left, expected 0", exp_a.size());
    end

    @(posedge clk);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
